serial_add_ctrl: RTL and testbench

- Multi-cycle sequencer around one full-adder bit slice, built from two half-adder cells plus an OR gate.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, and keeps the carry in a flip-flop between bits.
- Accepts operands and returns results over valid/ready handshakes.
- Used in area-constrained core variants where a WIDTH-bit parallel adder is not affordable.

---
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer, one full-adder slice
// reused LSB-first with the carry held in a flip-flop between bits.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds port SUB).

// serial_add_ha: single half-adder cell used to build the full-adder slice
module serial_add_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             SUB,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, acc_q, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q, cout_q, ovf_q;
    logic               p, g0, s, g1, c_next;
    logic               accept, last;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

`ifdef SERIAL_ADD_SUB_EN
    // subtract is A + ~B + 1, so CIN is ignored in that mode
    assign b_load = SUB ? ~B : B;
    assign c_load = SUB ? 1'b1 : CIN;
`else
    assign b_load = B;
    assign c_load = CIN;
`endif

    // full-adder slice: two half adders, carries merged by an OR gate
    serial_add_ha u_ha0 (.x(a_q[0]), .y(b_q[0]), .s(p), .c(g0));
    serial_add_ha u_ha1 (.x(p),      .y(c_q),    .s(s), .c(g1));
    assign c_next = g0 | g1;

    assign accept = IN_VALID && (state_q == S_IDLE);
    assign last   = (state_q == S_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));

    // state register
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = IN_VALID ? S_BUSY : S_IDLE;
            S_BUSY:  state_d = last ? S_DONE : S_BUSY;
            S_DONE:  state_d = OUT_READY ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // handshake and status outputs decoded from state
    always_comb begin
        IN_READY  = (state_q == S_IDLE);
        BUSY      = (state_q == S_BUSY);
        OUT_VALID = (state_q == S_DONE);
    end

    // datapath: load at accept, shift one bit per BUSY cycle, latch result on the MSB
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= b_load;
            c_q   <= c_load;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (state_q == S_BUSY) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= c_next;
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= {s, acc_q[WIDTH-1:1]};
            if (last) begin
                sum_q  <= {s, acc_q[WIDTH-1:1]};
                cout_q <= c_next;
                ovf_q  <= c_q ^ c_next;
            end
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
    logic       CLK = 1'b0;
    logic       RST_N, IN_VALID, OUT_READY, CIN;
    logic [7:0] A, B;
    logic       IN_READY, OUT_VALID, COUT, OVF, BUSY;
    logic [7:0] SUM;
`ifdef SERIAL_ADD_SUB_EN
    logic       SUB = 1'b0;
`endif
    int checks = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .CIN(CIN),
`ifdef SERIAL_ADD_SUB_EN
        .SUB(SUB),
`endif
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .SUM(SUM), .COUT(COUT), .OVF(OVF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] es, input logic ec, input logic eo);
        A = a; B = b; CIN = cin; IN_VALID = 1'b1; OUT_READY = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        SUB = sub;
`else
        if (sub) $display("note: %s subtract op skipped meaning, add-only build", tag);
`endif
        chk({tag, "_ready_pre"}, IN_READY, 1);
        tick();
        IN_VALID = 1'b0;
        chk({tag, "_busy"}, BUSY, 1);
        chk({tag, "_ready_low"}, IN_READY, 0);
        repeat (7) tick();
        chk({tag, "_not_early"}, OUT_VALID, 0);
        tick();
        chk({tag, "_valid"}, OUT_VALID, 1);
        chk({tag, "_sum"}, SUM, es);
        chk({tag, "_cout"}, COUT, ec);
        chk({tag, "_ovf"}, OVF, eo);
        tick();
        chk({tag, "_ready_post"}, IN_READY, 1);
        chk({tag, "_valid_post"}, OUT_VALID, 0);
        chk({tag, "_sum_kept"}, SUM, es);
    endtask

    logic [7:0] ta [4] = '{8'h35, 8'hC3, 8'h80, 8'h01};
    logic [7:0] tb [4] = '{8'h4A, 8'h5A, 8'h80, 8'hFE};
    logic       tc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; CIN = 1'b0; A = '0; B = '0;
        tick(); tick();
        chk("rst_ready", IN_READY, 1);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_ovf", OVF, 0);
        RST_N = 1'b1;
        tick();

        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add7f_01c", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
        run_op("addff_ffc", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("add80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // stall in DONE while pulsing new operands in BUSY and DONE
        A = 8'h12; B = 8'h34; CIN = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0;
        tick();
        IN_VALID = 1'b0;
        tick(); tick();
        A = 8'hAA; B = 8'hBB; CIN = 1'b1; IN_VALID = 1'b1;
        tick();
        chk("hold_busy_ignore", BUSY, 1);
        IN_VALID = 1'b0;
        repeat (5) tick();
        chk("hold_valid0", OUT_VALID, 1);
        chk("hold_sum0", SUM, 8'h46);
        for (int i = 0; i < 5; i++) begin
            IN_VALID = 1'b1;
            tick();
            chk("hold_valid", OUT_VALID, 1);
            chk("hold_sum", SUM, 8'h46);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        chk("hold_release_ready", IN_READY, 1);
        chk("hold_release_sum", SUM, 8'h46);

        // reset at the edge that would process bit 3
        A = 8'h55; B = 8'h11; CIN = 1'b0; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        repeat (3) tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("abort_ready", IN_READY, 1);
        chk("abort_valid", OUT_VALID, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_sum", SUM, 0);
        run_op("add10_20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        SUB = 1'b0;
`endif

        // back-to-back: IN_VALID and OUT_READY held high, accept every 10 cycles
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [8:0] full;
            logic       ev;
            A = ta[i]; B = tb[i]; CIN = tc[i];
            full = {1'b0, ta[i]} + {1'b0, tb[i]} + {8'h0, tc[i]};
            ev = (ta[i][7] == tb[i][7]) && (full[7] != ta[i][7]);
            chk("b2b_ready", IN_READY, 1);
            tick();
            chk("b2b_busy", BUSY, 1);
            A = ~ta[i]; B = 8'h00; CIN = ~tc[i];
            repeat (7) tick();
            chk("b2b_not_early", OUT_VALID, 0);
            tick();
            chk("b2b_valid", OUT_VALID, 1);
            chk("b2b_sum", SUM, full[7:0]);
            chk("b2b_cout", COUT, full[8]);
            chk("b2b_ovf", OVF, ev);
            tick();
        end
        IN_VALID = 1'b0;
        chk("b2b_end_ready", IN_READY, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
